// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: each trigger opens a LEN-cycle level window per channel,
// closed by a one-cycle done strobe on natural expiry (silent on clr abort or reset).
module pulse_stretch #(
  parameter int WIDTH  = 1,
  parameter int LEN    = 1000,
  parameter int CNT_W  = 16,
  parameter int RETRIG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] trig,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] done,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // cnt holds the remaining window cycles minus one, so LEN = 2**CNT_W still fits
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(LEN - 1);
  localparam bit               RETRIG_EN = (RETRIG != 0);

  state_t           state      [WIDTH];
  state_t           state_next [WIDTH];
  logic [CNT_W-1:0] cnt        [WIDTH];
  logic [CNT_W-1:0] cnt_next   [WIDTH];
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] done_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      level_out <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      level_out <= level_next;
      done      <= done_next;
      busy      <= |level_next;
    end
  end

  // Abort beats retrigger beats expiry; the decrement is only reached with cnt > 0
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (trig[i] && !clr[i]) begin
            state_next[i] = ACTIVE;
            cnt_next[i]   = RELOAD;
          end
        end
        ACTIVE: begin
          if (clr[i]) begin
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else if (trig[i] && RETRIG_EN) begin
            cnt_next[i]   = RELOAD;
          end else if (cnt[i] == '0) begin
            state_next[i] = IDLE;
          end else begin
            cnt_next[i]   = cnt[i] - CNT_W'(1);
          end
        end
        default: begin
          state_next[i] = IDLE;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

  // An ACTIVE->IDLE step without clr can only be a natural expiry
  always_comb begin
    level_next = '0;
    done_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level_next[i] = (state_next[i] == ACTIVE);
      done_next[i]  = (state[i] == ACTIVE) && (state_next[i] == IDLE) && !clr[i];
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three configurations share the same stimulus and are checked
// against a deadline-based reference model, a directed vector table and hand sequences.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] trig = 2'b00;
  logic [1:0] clr  = 2'b00;

  logic [1:0] lvlR, dnR, lvlN, dnN, lvl1, dn1;
  logic       busyR, busyN, busy1;

  int checkCount = 0;
  int errorCount = 0;
  int edgeNo     = 0;

  // Model: per config/channel, active flag, the edge at which the window expires, done flag
  bit mActive [3][2];
  int mEnd    [3][2];
  bit mDone   [3][2];

  typedef struct {
    logic [1:0] trig;
    logic [1:0] clr;
    logic [1:0] lvl;
    logic [1:0] dn;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  pulse_stretch #(.WIDTH(2), .LEN(4), .CNT_W(16), .RETRIG(1)) dutR (
    .clk(clk), .rst(rst), .trig(trig), .clr(clr),
    .level_out(lvlR), .done(dnR), .busy(busyR)
  );

  pulse_stretch #(.WIDTH(2), .LEN(4), .CNT_W(16), .RETRIG(0)) dutN (
    .clk(clk), .rst(rst), .trig(trig), .clr(clr),
    .level_out(lvlN), .done(dnN), .busy(busyN)
  );

  pulse_stretch #(.WIDTH(2), .LEN(1), .CNT_W(8), .RETRIG(1)) dut1 (
    .clk(clk), .rst(rst), .trig(trig), .clr(clr),
    .level_out(lvl1), .done(dn1), .busy(busy1)
  );

  function automatic int cfgLen(input int c);
    return (c == 2) ? 1 : 4;
  endfunction

  function automatic bit cfgRetrig(input int c);
    return (c != 1);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edgeNo, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++)
      for (int ch = 0; ch < 2; ch++) begin
        mActive[c][ch] = 1'b0;
        mEnd[c][ch]    = 0;
        mDone[c][ch]   = 1'b0;
      end
  endtask

  task automatic modelEdge();
    for (int c = 0; c < 3; c++)
      for (int ch = 0; ch < 2; ch++) begin
        mDone[c][ch] = 1'b0;
        if (mActive[c][ch]) begin
          if (clr[ch]) begin
            mActive[c][ch] = 1'b0;
          end else if (trig[ch] && cfgRetrig(c)) begin
            mEnd[c][ch] = edgeNo + cfgLen(c);
          end else if (edgeNo == mEnd[c][ch]) begin
            mActive[c][ch] = 1'b0;
            mDone[c][ch]   = 1'b1;
          end
        end else if (trig[ch] && !clr[ch]) begin
          mActive[c][ch] = 1'b1;
          mEnd[c][ch]    = edgeNo + cfgLen(c);
        end
      end
  endtask

  task automatic checkOutput();
    logic [1:0] expL [3];
    logic [1:0] expD [3];
    for (int c = 0; c < 3; c++) begin
      expL[c] = {mActive[c][1], mActive[c][0]};
      expD[c] = {mDone[c][1], mDone[c][0]};
    end
    check("len4-retrig level", lvlR, expL[0]);
    check("len4-retrig done",  dnR,  expD[0]);
    check("len4-retrig busy",  {1'b0, busyR}, {1'b0, |expL[0]});
    check("len4-noretrig level", lvlN, expL[1]);
    check("len4-noretrig done",  dnN,  expD[1]);
    check("len4-noretrig busy",  {1'b0, busyN}, {1'b0, |expL[1]});
    check("len1 level", lvl1, expL[2]);
    check("len1 done",  dn1,  expD[2]);
    check("len1 busy",  {1'b0, busy1}, {1'b0, |expL[2]});
  endtask

  task automatic applyStimulus(input logic [1:0] t, input logic [1:0] c);
    @(negedge clk);
    trig = t;
    clr  = c;
    @(posedge clk);
    edgeNo++;
    if (rst) modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeNo);
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    vecs[0]  = '{2'b01, 2'b00, 2'b01, 2'b00};
    vecs[1]  = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[2]  = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[3]  = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b01};
    vecs[5]  = '{2'b00, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{2'b01, 2'b00, 2'b01, 2'b00};
    vecs[7]  = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[8]  = '{2'b01, 2'b00, 2'b01, 2'b00};
    vecs[9]  = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[10] = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[11] = '{2'b00, 2'b00, 2'b01, 2'b00};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b01};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 2'b00};
    vecs[14] = '{2'b10, 2'b00, 2'b10, 2'b00};
    vecs[15] = '{2'b00, 2'b00, 2'b10, 2'b00};
    vecs[16] = '{2'b00, 2'b10, 2'b00, 2'b00};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 2'b00};
    vecs[18] = '{2'b10, 2'b10, 2'b00, 2'b00};
    vecs[19] = '{2'b00, 2'b00, 2'b00, 2'b00};

    modelReset();
    #12;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00);

    $display("[TB] directed vector table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].trig, vecs[i].clr);
      check("table level", lvlR, vecs[i].lvl);
      check("table done",  dnR,  vecs[i].dn);
      check("table busy",  {1'b0, busyR}, {1'b0, |vecs[i].lvl});
    end

    $display("[TB] retrigger ignored when RETRIG=0");
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00);
    check("noretrig level on last cycle", lvlN, 2'b01);
    applyStimulus(2'b00, 2'b00);
    check("noretrig expiry level", lvlN, 2'b00);
    check("noretrig expiry done",  dnN,  2'b01);
    check("retrig still high",     lvlR, 2'b01);
    check("retrig no done",        dnR,  2'b00);
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 2'b00);

    $display("[TB] LEN=1 held trigger");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'b00);
      check("len1 held level", lvl1, 2'b01);
      check("len1 held done",  dn1,  2'b00);
    end
    applyStimulus(2'b00, 2'b00);
    check("len1 fall level", lvl1, 2'b00);
    check("len1 fall done",  dn1,  2'b01);
    applyStimulus(2'b00, 2'b00);
    check("len1 done single", dn1, 2'b00);
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 2'b00);

    $display("[TB] asynchronous reset mid-window");
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b00, 2'b00);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    check("async reset level", lvlR, 2'b00);
    check("async reset busy",  {1'b0, busyR}, 2'b00);
    checkOutput();
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);
    check("post-reset idle", lvlR, 2'b00);
    applyStimulus(2'b01, 2'b00);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 2'b00);

    $display("[TB] randomized stimulus against model");
    for (int i = 0; i < 400; i++) begin
      logic [1:0] t;
      logic [1:0] c;
      for (int b = 0; b < 2; b++) begin
        t[b] = ($urandom_range(0, 3) == 0);
        c[b] = ($urandom_range(0, 11) == 0);
      end
      applyStimulus(t, c);
    end
    for (int i = 0; i < 6; i++) applyStimulus(2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
